seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits; legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 16: width of the match counter.
REQ-003 SHALL have parameter RESET_PATTERN, default 8'b0000_1101: pattern loaded at reset, LSB-aligned.
REQ-004 SHALL have parameter RESET_LEN, default 4: pattern length loaded at reset.
REQ-005 SHALL have parameter RESET_OVERLAP, default 1: overlap mode loaded at reset.
REQ-006 SHALL have port clock, input, 1: rising-edge clock for all state.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port i, input, 1: serial data bit.
REQ-009 SHALL have port in_valid, input, 1: qualifies i; the bit is accepted on a clock edge with in_valid=1.
REQ-010 SHALL have port cfg_we, input, 1: configuration write strobe.
REQ-011 SHALL have port cfg_pattern, input, MAX_LEN: new pattern, LSB-aligned; bit cfg_len-1 is the first bit received.
REQ-012 SHALL have port cfg_len, input, clog2(MAX_LEN+1): new pattern length.
REQ-013 SHALL have port cfg_overlap, input, 1: 1 = overlapping matches; 0 = history cleared after each match.
REQ-014 SHALL have port out, output, 1: registered one-cycle match pulse.
REQ-015 SHALL have port match_count, output, CNT_W: saturating count of matches.
REQ-016 SHALL have port fill, output, clog2(MAX_LEN+1): number of valid history bits.
REQ-017 SHALL have port cfg_err, output, 1: one-cycle pulse when a configuration write is rejected.

Function
REQ-018 SHALL keep a MAX_LEN-bit history register hist; an accepted bit shifts in at LSB: hist <= {hist[MAX_LEN-2:0], i}.
REQ-019 SHALL increment fill on each accepted bit, saturating at MAX_LEN.
REQ-020 SHALL detect a match on an accepted bit when the post-shift fill >= len and the post-shift hist[len-1:0] == pattern[len-1:0]; bits at len and above are ignored.
REQ-021 SHALL assert out for exactly one cycle, in the cycle after the clock edge that accepted the completing bit (latency 1); out=0 in all other cycles.
REQ-022 SHALL, with overlap=1, keep history after a match, so the pattern's suffix can start the next match.
REQ-023 SHALL, with overlap=0, set fill to 0 on the matching edge, so no bit of a matched sequence counts toward the next match.
REQ-024 SHALL hold hist, fill and out=0 on cycles with in_valid=0; gaps SHALL NOT break a sequence.
REQ-025 SHALL increment match_count by 1 per match, saturating at 2^CNT_W-1 (no wrap); out still pulses when saturated.
REQ-026 SHALL, on cfg_we with 2 <= cfg_len <= MAX_LEN, on that edge: latch pattern, len and overlap; clear fill to 0; leave match_count unchanged; ignore any in_valid bit on that edge; force out=0 next cycle.
REQ-027 SHALL, on cfg_we with cfg_len < 2 or cfg_len > MAX_LEN, keep the configuration and history unchanged, pulse cfg_err for one cycle, and process any same-cycle in_valid bit normally.
REQ-028 SHALL treat i as don't-care when in_valid=0; X on i with in_valid=0 SHALL NOT propagate.

Reset
REQ-029 SHALL, with reset=1 at a clock edge, set hist=0, fill=0, out=0, cfg_err=0, match_count=0, pattern=RESET_PATTERN, len=RESET_LEN and overlap=RESET_OVERLAP.
REQ-030 SHALL give reset priority over cfg_we and in_valid in the same cycle; inputs on a reset edge SHALL be discarded.
REQ-031 SHALL start detecting on the first edge after reset deasserts; a partial sequence in progress when reset asserts SHALL be lost.

Verification
REQ-032 Default config, overlap=1, i stream 1,1,0,1,1,0,1 with in_valid=1 -> out pulses the cycle after bit 4 and after bit 7; match_count=2.
REQ-033 Same stream after a cfg write (pattern=1101, len=4, overlap=0) -> single pulse after bit 4; match_count=1; fill=3 at end.
REQ-034 Stream 1,1,0,1 with in_valid=0 for 3 cycles between each bit -> one pulse, one cycle after bit 4 is accepted; fill holds during gaps.
REQ-035 cfg_we with cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulses once per write; detection of 1101 unaffected.
REQ-036 CNT_W=2, six matches of 1101 -> match_count stops at 3; out pulses six times.
REQ-037 Reset asserted after 1,1,0 and released, then 1 -> no pulse; then 1,1,0,1 -> one pulse.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-programmable pattern, length and
// overlap mode, plus a saturating match counter.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 16,
    parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(8'b0000_1101),
    parameter int RESET_LEN = 4,
    parameter bit RESET_OVERLAP = 1'b1,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i,
    input  logic               in_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    output logic               out,
    output logic [CNT_W-1:0]   match_count,
    output logic [LW-1:0]      fill,
    output logic               cfg_err
);

    localparam logic [LW-1:0] MAXL = LW'(MAX_LEN);
    localparam logic [LW-1:0] MINL = LW'(2);

    logic [MAX_LEN-1:0] hist, pattern, hist_nxt, mask;
    logic [LW-1:0]      len, fill_nxt;
    logic               overlap, cfg_ok, accept, match, bit_in;

    assign cfg_ok   = cfg_we && (cfg_len >= MINL) && (cfg_len <= MAXL);
    // A valid config write owns the edge; the data bit on it is dropped.
    assign accept   = in_valid && !cfg_ok;
    // Gate i so an undriven input while idle can never reach state.
    assign bit_in   = in_valid & i;
    assign hist_nxt = {hist[MAX_LEN-2:0], bit_in};
    assign fill_nxt = (fill == MAXL) ? fill : fill + LW'(1);

    always_comb begin
        mask = '0;
        for (int k = 0; k < MAX_LEN; k++)
            mask[k] = (k < int'(len));
    end

    assign match = accept && (fill_nxt >= len) && (((hist_nxt ^ pattern) & mask) == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            hist        <= '0;
            fill        <= '0;
            out         <= 1'b0;
            cfg_err     <= 1'b0;
            match_count <= '0;
            pattern     <= RESET_PATTERN;
            len         <= LW'(RESET_LEN);
            overlap     <= RESET_OVERLAP;
        end else begin
            out     <= match;
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_ok) begin
                pattern <= cfg_pattern;
                len     <= cfg_len;
                overlap <= cfg_overlap;
                fill    <= '0;
            end else if (accept) begin
                hist <= hist_nxt;
                fill <= (match && !overlap) ? '0 : fill_nxt;
            end
            if (match && (match_count != '1))
                match_count <= match_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed table-driven bench for seq_detector_param, with a second
// narrow-counter instance sharing the stimulus for saturation checks.
module tb_seq_detector_param;

    logic        clock = 1'b0;
    logic        reset, i, in_valid, cfg_we, cfg_overlap;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        out, cfg_err, out2, cfg_err2;
    logic [15:0] match_count;
    logic [1:0]  match_count2;
    logic [3:0]  fill, fill2;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    seq_detector_param dut (
        .clock(clock), .reset(reset), .i(i), .in_valid(in_valid),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .out(out), .match_count(match_count),
        .fill(fill), .cfg_err(cfg_err)
    );

    seq_detector_param #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .i(i), .in_valid(in_valid),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .out(out2), .match_count(match_count2),
        .fill(fill2), .cfg_err(cfg_err2)
    );

    typedef struct {
        logic        r, we, v, b;
        logic [7:0]  pat;
        logic [3:0]  len;
        logic        ov;
        logic        eo;
        logic [15:0] ec;
        logic [3:0]  ef;
        logic        ee;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic we, logic v, logic b, logic [7:0] pat,
                                logic [3:0] len, logic ov, logic eo, logic [15:0] ec,
                                logic [3:0] ef, logic ee);
        vec_t t;
        t.r = r; t.we = we; t.v = v; t.b = b; t.pat = pat; t.len = len; t.ov = ov;
        t.eo = eo; t.ec = ec; t.ef = ef; t.ee = ee;
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the active edge.
    task automatic step(input logic r, input logic we, input logic v, input logic b,
                        input logic [7:0] pat, input logic [3:0] len, input logic ov);
        reset = r; cfg_we = we; in_valid = v; i = b;
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
        @(posedge clock);
        #1;
    endtask

    task automatic bit_in(input logic b);
        step(1'b0, 1'b0, 1'b1, b, 8'h00, 4'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; i = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        @(posedge clock); #1;

        //           r  we v  b      pat  len ov   eo ec  ef ee
        tbl.push_back(mk(1, 0, 0, 0,  8'h00, 0, 0,  0, 0, 0, 0));
        // default 1101 overlapping
        tbl.push_back(mk(0, 0, 1, 1,  8'h00, 0, 0,  0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1,  8'h00, 0, 0,  0, 0, 2, 0));
        tbl.push_back(mk(0, 0, 1, 0,  8'h00, 0, 0,  0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 1, 1,  8'h00, 0, 0,  1, 1, 4, 0));
        tbl.push_back(mk(0, 0, 1, 1,  8'h00, 0, 0,  0, 1, 5, 0));
        tbl.push_back(mk(0, 0, 1, 0,  8'h00, 0, 0,  0, 1, 6, 0));
        tbl.push_back(mk(0, 0, 1, 1,  8'h00, 0, 0,  1, 2, 7, 0));
        // non-overlapping; bit on the write edge is dropped
        tbl.push_back(mk(0, 1, 1, 1,  8'h0D, 4, 0,  0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1,  8'h00, 0, 0,  0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1,  8'h00, 0, 0,  0, 2, 2, 0));
        tbl.push_back(mk(0, 0, 1, 0,  8'h00, 0, 0,  0, 2, 3, 0));
        tbl.push_back(mk(0, 0, 1, 1,  8'h00, 0, 0,  1, 3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1,  8'h00, 0, 0,  0, 3, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0,  8'h00, 0, 0,  0, 3, 2, 0));
        tbl.push_back(mk(0, 0, 1, 1,  8'h00, 0, 0,  0, 3, 3, 0));
        // back to overlapping, then rejected writes still pass their bits
        tbl.push_back(mk(0, 1, 1, 0,  8'h0D, 4, 1,  0, 3, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1,  8'hFF, 0, 0,  0, 3, 1, 1));
        tbl.push_back(mk(0, 1, 1, 1,  8'hFF, 9, 0,  0, 3, 2, 1));
        tbl.push_back(mk(0, 0, 0, 'x, 8'h00, 0, 0,  0, 3, 2, 0));
        tbl.push_back(mk(0, 0, 1, 0,  8'h00, 0, 0,  0, 3, 3, 0));
        tbl.push_back(mk(0, 0, 1, 1,  8'h00, 0, 0,  1, 4, 4, 0));

        foreach (tbl[k]) begin
            step(tbl[k].r, tbl[k].we, tbl[k].v, tbl[k].b, tbl[k].pat, tbl[k].len, tbl[k].ov);
            chk($sformatf("v%0d.out", k),   {15'd0, out},     {15'd0, tbl[k].eo});
            chk($sformatf("v%0d.count", k), match_count,      tbl[k].ec);
            chk($sformatf("v%0d.fill", k),  {12'd0, fill},    {12'd0, tbl[k].ef});
            chk($sformatf("v%0d.err", k),   {15'd0, cfg_err}, {15'd0, tbl[k].ee});
        end

        // reset beats a same-edge config write and data bit
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 4'd3, 1'b0);
        chk("rst.count", match_count, 16'd0);
        chk("rst.fill", {12'd0, fill}, 16'd0);
        chk("rst.out", {15'd0, out}, 16'd0);
        bit_in(1); bit_in(1); bit_in(0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'd0, 1'b0);
        chk("rst2.fill", {12'd0, fill}, 16'd0);
        bit_in(1);
        chk("rst.partial_lost", {15'd0, out}, 16'd0);
        bit_in(1); chk("rst.s1", {15'd0, out}, 16'd0);
        bit_in(1); chk("rst.s2", {15'd0, out}, 16'd0);
        bit_in(0); chk("rst.s3", {15'd0, out}, 16'd0);
        bit_in(1); chk("rst.s4", {15'd0, out}, 16'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        chk("rst.pulse_end", {15'd0, out}, 16'd0);
        chk("rst.count_after", match_count, 16'd1);

        // idle gaps between accepted bits, i toggling while idle
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        begin
            logic [3:0] gs;
            gs = 4'b1101;
            for (int k = 0; k < 4; k++) begin
                bit_in(gs[3-k]);
                chk($sformatf("gap.b%0d.out", k), {15'd0, out}, (k == 3) ? 16'd1 : 16'd0);
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, 1'b0, g[0], 8'h00, 4'd0, 1'b0);
                    chk($sformatf("gap.b%0d.g%0d.out", k, g), {15'd0, out}, 16'd0);
                    chk($sformatf("gap.b%0d.g%0d.fill", k, g), {12'd0, fill}, 16'(k + 1));
                end
            end
            chk("gap.count", match_count, 16'd1);
        end

        // saturating 2-bit counter over six back-to-back matches
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        for (int m = 1; m <= 6; m++) begin
            bit_in(1); bit_in(1); bit_in(0); bit_in(1);
            chk($sformatf("sat.m%0d.out", m), {15'd0, out2}, 16'd1);
            chk($sformatf("sat.m%0d.count", m), {14'd0, match_count2}, (m > 3) ? 16'd3 : 16'(m));
        end
        chk("sat.wide_count", match_count, 16'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
